mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one registered Wishbone-style memory bus between instruction fetch (I) and the MEM stage data port (D).
//  Converts the single-cycle ce/addr requests from IF and MEM into bus cycles, holds each result until the pipeline advances.
//  Raises per-port stall requests to the pipeline controller while an access is outstanding.
// PARAMETERS
//  TIMEOUT_CYC  255  bus cycles without ack before forced termination; 0 disables the timeout
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, synchronous, active-high
//  stall_i         in   1   pipeline stalled this cycle (from ctrl); 0 = pipeline advances
//  flush_i         in   1   pipeline flush (exception); discards pending/held results
//  if_ce_i         in   1   I port request (read only)
//  if_addr_i       in   32  I port byte address
//  if_data_o       out  32  I port read data; valid while I done flag set, else 0
//  if_stallreq_o   out  1   = if_ce_i & ~i_done (combinational)
//  mem_ce_i        in   1   D port request
//  mem_we_i        in   1   D port write enable
//  mem_sel_i       in   4   D port byte lane select
//  mem_addr_i      in   32  D port byte address
//  mem_data_i      in   32  D port write data
//  mem_data_o      out  32  D port read data; valid while D done flag set, else 0
//  mem_stallreq_o  out  1   = mem_ce_i & ~d_done (combinational)
//  bus_cyc_o/bus_stb_o out 1 bus cycle/strobe (registered, always equal)
//  bus_we_o        out  1   bus write enable (registered)
//  bus_sel_o       out  4   bus byte select (registered; I port drives 4'b1111)
//  bus_adr_o       out  32  bus address (registered)
//  bus_dat_o       out  32  bus write data (registered; 0 for reads)
//  bus_dat_i       in   32  bus read data, sampled on bus_ack_i
//  bus_ack_i       in   1   bus acknowledge, single-cycle
//  bus_err_o       out  1   one-cycle pulse on timeout termination
// BEHAVIOUR
//  Reset: state IDLE; all bus_* outputs 0; done flags 0; buffers 0; bus_err_o 0; flush_pend 0; counter 0.
//  FSM states: IDLE, BUSY_I, BUSY_D.
//  IDLE: eligible = ce & ~done & ~flush_i. D eligible -> latch D addr/we/sel/data onto bus regs, cyc=stb=1, go BUSY_D.
//   Else I eligible -> latch if_addr_i, we=0, sel=1111, go BUSY_I. Fixed priority D over I (D is older instruction).
//  BUSY_x: bus regs held constant; counter increments each cycle.
//   bus_ack_i=1 -> cyc/stb/we/sel/adr/dat cleared next edge, state IDLE; unless flush_pend, x_done<=1 and buf_x<=bus_dat_i (writes store 0).
//   counter reaches TIMEOUT_CYC (nonzero) without ack -> same termination, buf_x<=0, bus_err_o=1 for 1 cycle.
//  Min latency: request seen at edge T, cyc high after T, ack at earliest in cycle T+1, done/stallreq low from T+2.
//  Back-to-back: IDLE is always visited for one cycle between bus cycles (cyc low >=1 cycle).
//  Done flags (per port): set on ack/timeout, cleared on any edge with stall_i=0 or flush_i=1; set wins over clear
//   in the same cycle (ack cycle always has stallreq=1, so stall_i=1 there by ctrl contract).
//  Flush: never aborts an in-flight bus cycle (writes must complete); sets flush_pend, cleared at termination;
//   result of that cycle is discarded. flush_i and ack in same cycle -> discarded. flush_i blocks new grants in IDLE.
//  Pipeline stalled by other port: a port with done=1 holds data_o stable and keeps stallreq low indefinitely;
//   the bus stays free for the other port (no deadlock).
//  ce deasserted mid bus cycle: cycle still completes; done flag set then cleared when stall_i=0.
//  rst mid-cycle: bus outputs drop next edge; outstanding ack ignored.
// STRUCTURE
//  Shared defines file: FSM state encodings, Enable/Disable, ZeroWord, SelAll(4'b1111).
//  Sub-module mem_bus_slot (instantiated twice, I and D): done flag + 32-bit result buffer + stallreq/data_o logic.
//  Top holds FSM, grant muxing, bus registers, timeout counter, flush_pend.
// TESTING
//  I read, ack after 3 cycles, data 0x24010005 -> bus_adr=if_addr, sel=1111; if_stallreq low 1 cycle after ack; if_data_o=0x24010005.
//  Simultaneous if_ce/mem_ce (D write 0xDEADBEEF, sel 0011 @0x100) -> D granted first, we=1; I granted after 1 idle cycle.
//  D done while stall_i held 1 for 5 cycles by I -> mem_data_o stable, mem_stallreq 0, I bus cycle proceeds.
//  flush_i during BUSY_D write -> write completes on bus, d_done stays 0, no grant while flush_i=1.
//  No ack, TIMEOUT_CYC=4 -> cyc drops after 4 cycles, bus_err_o 1-cycle pulse, data_o=0, stallreq released.
//  rst asserted during BUSY_I -> all bus outputs 0 next edge, state IDLE, late ack ignored.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the I/D memory bus arbiter: FSM encodings and bus constants.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL   = 4'b1111;

endpackage

// File: rtl/mem_bus_slot.sv
// Per-port result holder: done flag plus result buffer, driving the port's stall request
// and read data back to the pipeline.
module mem_bus_slot
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        set_i,
  input  logic [31:0] res_i,
  output logic        done_o,
  output logic        stallreq_o,
  output logic [31:0] data_o
);

  logic        done_q;
  logic [31:0] buf_q;

  // A new result wins over the pipeline-advance clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= DISABLE;
      buf_q  <= ZERO_WORD;
    end else if (set_i) begin
      done_q <= ENABLE;
      buf_q  <= res_i;
    end else if (!stall_i || flush_i) begin
      done_q <= DISABLE;
    end
  end

  assign done_o     = done_q;
  assign stallreq_o = ce_i & ~done_q;
  assign data_o     = done_q ? buf_q : ZERO_WORD;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one registered Wishbone-style bus between instruction fetch and the MEM data port,
// with fixed D-over-I priority, flush-safe completion and an optional ack timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYC != 0);

  arb_state_e       state_q;
  logic             cyc_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [31:0]      adr_q;
  logic [31:0]      dat_q;
  logic             err_q;
  logic             flush_pend_q;
  logic [CNT_W-1:0] cnt_q;

  logic        i_done, d_done;
  logic        i_elig, d_elig;
  logic        busy, timeout_hit, term, keep;
  logic        i_set, d_set;
  logic [31:0] res;

  assign i_elig      = if_ce_i & ~i_done & ~flush_i;
  assign d_elig      = mem_ce_i & ~d_done & ~flush_i;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_hit = TO_EN && busy && !bus_ack_i && (cnt_q == CNT_LAST);
  assign term        = busy && (bus_ack_i || timeout_hit);
  // A flush seen at any point of the bus cycle, including its last cycle, drops the result.
  assign keep        = ~(flush_pend_q | flush_i);
  assign i_set       = term && (state_q == ST_BUSY_I) && keep;
  assign d_set       = term && (state_q == ST_BUSY_D) && keep;
  assign res         = (bus_ack_i && !we_q) ? bus_dat_i : ZERO_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= DISABLE;
      we_q         <= DISABLE;
      sel_q        <= 4'b0000;
      adr_q        <= ZERO_WORD;
      dat_q        <= ZERO_WORD;
      err_q        <= DISABLE;
      flush_pend_q <= DISABLE;
      cnt_q        <= '0;
    end else begin
      err_q <= DISABLE;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (d_elig) begin
            state_q <= ST_BUSY_D;
            cyc_q   <= ENABLE;
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            adr_q   <= mem_addr_i;
            dat_q   <= mem_we_i ? mem_data_i : ZERO_WORD;
          end else if (i_elig) begin
            state_q <= ST_BUSY_I;
            cyc_q   <= ENABLE;
            we_q    <= DISABLE;
            sel_q   <= SEL_ALL;
            adr_q   <= if_addr_i;
            dat_q   <= ZERO_WORD;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // In-flight cycles always run to ack or timeout; a flush only marks the result stale.
          if (term) begin
            state_q      <= ST_IDLE;
            cyc_q        <= DISABLE;
            we_q         <= DISABLE;
            sel_q        <= 4'b0000;
            adr_q        <= ZERO_WORD;
            dat_q        <= ZERO_WORD;
            err_q        <= timeout_hit;
            flush_pend_q <= DISABLE;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (flush_i) flush_pend_q <= ENABLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_bus_slot u_slot_i (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (if_ce_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .set_i      (i_set),
    .res_i      (res),
    .done_o     (i_done),
    .stallreq_o (if_stallreq_o),
    .data_o     (if_data_o)
  );

  mem_bus_slot u_slot_d (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (mem_ce_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .set_i      (d_set),
    .res_i      (res),
    .done_o     (d_done),
    .stallreq_o (mem_stallreq_o),
    .data_o     (mem_data_o)
  );

  assign bus_cyc_o = cyc_q;
  assign bus_stb_o = cyc_q;
  assign bus_we_o  = we_q;
  assign bus_sel_o = sel_q;
  assign bus_adr_o = adr_q;
  assign bus_dat_o = dat_q;
  assign bus_err_o = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stall_i is modelled as a pipeline controller
// (OR of both stall requests plus a forced stall), the bus slave is driven by hand.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, stall_force, flush_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i, if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i, mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic        mem_stallreq_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o, bus_ack_i;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign stall_i = if_stallreq_o | mem_stallreq_o | stall_force;

  mem_bus_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_stallreq_o(mem_stallreq_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; stall_force = 1'b0; flush_i = 1'b0;
    if_ce_i = 1'b0; if_addr_i = '0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
    bus_ack_i = 1'b0; bus_dat_i = '0;
    step; step;
    n_cmp++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o} !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o}); end
    n_cmp++; if ({bus_sel_o, bus_adr_o, bus_dat_o} !== 68'h0) begin n_err++; $display("FAIL reset_bus: sel %h adr %h dat %h want 0", bus_sel_o, bus_adr_o, bus_dat_o); end
    n_cmp++; if ({if_data_o, mem_data_o, if_stallreq_o, mem_stallreq_o} !== 66'h0) begin n_err++; $display("FAIL reset_port: if %h mem %h sr %b%b want 0", if_data_o, mem_data_o, if_stallreq_o, mem_stallreq_o); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_read;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_1000;
    step;
    n_cmp++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o} !== 7'b1101111) begin n_err++; $display("FAIL read_ctl: got %b want 1101111", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o}); end
    n_cmp++; if (bus_adr_o !== 32'h0000_1000) begin n_err++; $display("FAIL read_adr: got %h want 00001000", bus_adr_o); end
    n_cmp++; if (if_stallreq_o !== 1'b1) begin n_err++; $display("FAIL read_stallreq_busy: got %b want 1", if_stallreq_o); end
    step; step;
    bus_ack_i = 1'b1; bus_dat_i = 32'h2401_0005;
    step;
    bus_ack_i = 1'b0;
    n_cmp++; if (if_data_o !== 32'h2401_0005) begin n_err++; $display("FAIL read_data: got %h want 24010005", if_data_o); end
    n_cmp++; if ({if_stallreq_o, bus_cyc_o, bus_err_o} !== 3'b000) begin n_err++; $display("FAIL read_done: sr/cyc/err %b want 000", {if_stallreq_o, bus_cyc_o, bus_err_o}); end
    if_ce_i = 1'b0;
    step;
    n_cmp++; if ({if_data_o, bus_cyc_o} !== 33'h0) begin n_err++; $display("FAIL read_clear: data %h cyc %b want 0", if_data_o, bus_cyc_o); end
  endtask

  task automatic test_priority;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h100; mem_data_i = 32'hDEAD_BEEF;
    if_ce_i = 1'b1; if_addr_i = 32'h2000;
    step;
    n_cmp++; if ({bus_cyc_o, bus_we_o, bus_sel_o} !== 6'b110011) begin n_err++; $display("FAIL prio_d_ctl: got %b want 110011", {bus_cyc_o, bus_we_o, bus_sel_o}); end
    n_cmp++; if ({bus_adr_o, bus_dat_o} !== {32'h100, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL prio_d_adr_dat: got %h %h want 00000100 deadbeef", bus_adr_o, bus_dat_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h5555_5555;
    step;
    bus_ack_i = 1'b0;
    n_cmp++; if ({bus_cyc_o, mem_stallreq_o, if_stallreq_o} !== 3'b001) begin n_err++; $display("FAIL prio_idle_gap: cyc/msr/isr %b want 001", {bus_cyc_o, mem_stallreq_o, if_stallreq_o}); end
    n_cmp++; if (mem_data_o !== 32'h0) begin n_err++; $display("FAIL prio_write_data: got %h want 0", mem_data_o); end
    step;
    n_cmp++; if ({bus_cyc_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o} !== {2'b10, 4'b1111, 32'h2000, 32'h0}) begin n_err++; $display("FAIL prio_i_grant: cyc %b we %b sel %b adr %h dat %h", bus_cyc_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o); end
    step;
    bus_ack_i = 1'b1; bus_dat_i = 32'h8C22_0004;
    step;
    bus_ack_i = 1'b0;
    n_cmp++; if ({if_data_o, if_stallreq_o, bus_cyc_o} !== {32'h8C22_0004, 2'b00}) begin n_err++; $display("FAIL prio_i_done: data %h sr %b cyc %b", if_data_o, if_stallreq_o, bus_cyc_o); end
    if_ce_i = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    step;
    n_cmp++; if ({if_data_o, mem_data_o, bus_cyc_o} !== 65'h0) begin n_err++; $display("FAIL prio_clear: if %h mem %h cyc %b", if_data_o, mem_data_o, bus_cyc_o); end
  endtask

  task automatic test_stall_hold;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h200;
    step;
    n_cmp++; if ({bus_cyc_o, bus_we_o, bus_adr_o} !== {2'b10, 32'h200}) begin n_err++; $display("FAIL hold_d_grant: cyc %b we %b adr %h", bus_cyc_o, bus_we_o, bus_adr_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h1122_3344;
    step;
    bus_ack_i = 1'b0;
    stall_force = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h3000;
    for (int k = 0; k < 3; k++) begin
      step;
      n_cmp++; if ({mem_data_o, mem_stallreq_o, bus_cyc_o} !== {32'h1122_3344, 2'b01}) begin n_err++; $display("FAIL hold_d_stable%0d: data %h sr %b cyc %b", k, mem_data_o, mem_stallreq_o, bus_cyc_o); end
    end
    n_cmp++; if (bus_adr_o !== 32'h3000) begin n_err++; $display("FAIL hold_i_adr: got %h want 00003000", bus_adr_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'hCAFE_F00D;
    step;
    bus_ack_i = 1'b0;
    step;
    n_cmp++; if ({if_data_o, mem_data_o, if_stallreq_o, bus_cyc_o} !== {32'hCAFE_F00D, 32'h1122_3344, 2'b00}) begin n_err++; $display("FAIL hold_both: if %h mem %h sr %b cyc %b", if_data_o, mem_data_o, if_stallreq_o, bus_cyc_o); end
    stall_force = 1'b0; if_ce_i = 1'b0; mem_ce_i = 1'b0;
    step;
    n_cmp++; if ({if_data_o, mem_data_o} !== 64'h0) begin n_err++; $display("FAIL hold_release: if %h mem %h want 0", if_data_o, mem_data_o); end
  endtask

  task automatic test_flush;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h400; mem_data_i = 32'hA5A5_A5A5;
    step;
    flush_i = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h80;
    step;
    n_cmp++; if ({bus_cyc_o, bus_we_o, bus_adr_o, bus_dat_o} !== {2'b11, 32'h400, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL flush_inflight: cyc %b we %b adr %h dat %h", bus_cyc_o, bus_we_o, bus_adr_o, bus_dat_o); end
    flush_i = 1'b0;
    step;
    n_cmp++; if (bus_cyc_o !== 1'b1) begin n_err++; $display("FAIL flush_no_abort: cyc %b want 1", bus_cyc_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h0;
    step;
    bus_ack_i = 1'b0; flush_i = 1'b1;
    n_cmp++; if ({bus_cyc_o, mem_stallreq_o, mem_data_o} !== {2'b01, 32'h0}) begin n_err++; $display("FAIL flush_discard: cyc %b dsr %b data %h", bus_cyc_o, mem_stallreq_o, mem_data_o); end
    step;
    n_cmp++; if (bus_cyc_o !== 1'b0) begin n_err++; $display("FAIL flush_block_grant: cyc %b want 0", bus_cyc_o); end
    flush_i = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    step;
    n_cmp++; if ({bus_cyc_o, bus_adr_o} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL flush_after_grant: cyc %b adr %h", bus_cyc_o, bus_adr_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h0000_0013;
    step;
    bus_ack_i = 1'b0;
    n_cmp++; if (if_data_o !== 32'h13) begin n_err++; $display("FAIL flush_after_data: got %h want 00000013", if_data_o); end
    if_ce_i = 1'b0;
    step;
  endtask

  task automatic test_timeout;
    if_ce_i = 1'b1; if_addr_i = 32'h500;
    for (int k = 0; k < 4; k++) begin
      step;
      n_cmp++; if ({bus_cyc_o, bus_err_o} !== 2'b10) begin n_err++; $display("FAIL to_busy%0d: cyc/err %b want 10", k, {bus_cyc_o, bus_err_o}); end
    end
    step;
    n_cmp++; if ({bus_cyc_o, bus_err_o, if_stallreq_o, if_data_o} !== {3'b010, 32'h0}) begin n_err++; $display("FAIL to_term: cyc %b err %b sr %b data %h", bus_cyc_o, bus_err_o, if_stallreq_o, if_data_o); end
    if_ce_i = 1'b0;
    step;
    n_cmp++; if ({bus_err_o, bus_cyc_o} !== 2'b00) begin n_err++; $display("FAIL to_err_pulse: err/cyc %b want 00", {bus_err_o, bus_cyc_o}); end
  endtask

  task automatic test_reset_mid;
    if_ce_i = 1'b1; if_addr_i = 32'h600;
    step;
    n_cmp++; if (bus_cyc_o !== 1'b1) begin n_err++; $display("FAIL rstmid_grant: cyc %b want 1", bus_cyc_o); end
    rst = 1'b1;
    step;
    n_cmp++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o} !== 71'h0) begin n_err++; $display("FAIL rstmid_bus: cyc %b sel %b adr %h dat %h", bus_cyc_o, bus_sel_o, bus_adr_o, bus_dat_o); end
    rst = 1'b0; if_ce_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'hBAD0_BAD0;
    step;
    bus_ack_i = 1'b0;
    n_cmp++; if ({if_data_o, bus_cyc_o, bus_err_o} !== 34'h0) begin n_err++; $display("FAIL rstmid_late_ack: data %h cyc %b err %b", if_data_o, bus_cyc_o, bus_err_o); end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_read;
    test_priority;
    test_stall_hold;
    test_flush;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
